// File: rtl/func_sweep_pkg.sv
// Shared types and defaults for the SOP/POS function-pair sweep sequencer.
// Optional build macro honoured by func_sweep_ctrl: SWEEP_ERR_STOP_EN.
package func_sweep_pkg;

   localparam int NVARS_DEF      = 3;
   localparam int SETTLE_CYC_DEF = 1;

   function automatic int tbl_w(input int nvars);
      return 2 ** nvars;
   endfunction

   localparam int TBL_W = tbl_w(NVARS_DEF);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/func_sweep_ctrl_if.sv
// Sweep bus between the sequencer (master) and the function-pair datapath / host (slave).
interface func_sweep_ctrl_if
   import func_sweep_pkg::*;
#(
   parameter int NVARS = NVARS_DEF
);
   localparam int TW = tbl_w(NVARS);

   logic             start;
   logic             fs_in;
   logic             fp_in;
   logic [NVARS-1:0] vec_out;
   logic             busy;
   logic             done;
   logic [TW-1:0]    truth_sop;
   logic [TW-1:0]    truth_pos;
   logic             mismatch;
   logic [NVARS:0]   mismatch_cnt;

   modport master (
      input  start, fs_in, fp_in,
      output vec_out, busy, done, truth_sop, truth_pos, mismatch, mismatch_cnt
   );

   modport slave (
      output start, fs_in, fp_in,
      input  vec_out, busy, done, truth_sop, truth_pos, mismatch, mismatch_cnt
   );

endinterface

// File: rtl/func_sweep_settle.sv
// Loadable settle down-counter; o_expired is high once the input vector has been held long enough.
module func_sweep_settle #(
   parameter int SETTLE_CYC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   logic [CW-1:0] r_cnt;

   // Loaded one below SETTLE_CYC so the SETTLE state lasts exactly SETTLE_CYC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CW'(SETTLE_CYC - 1);
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/func_sweep_ctrl.sv
// Sweeps {x,y,z} through every minterm, samples SOP/POS outputs and counts disagreements.
// Build macro SWEEP_ERR_STOP_EN: end the sweep at the first disagreeing minterm.
module func_sweep_ctrl
   import func_sweep_pkg::*;
#(
   parameter int NVARS      = NVARS_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input logic               clk,
   input logic               rst_n,
   func_sweep_ctrl_if.master bus
);
   localparam int                TW       = tbl_w(NVARS);
   localparam logic [NVARS-1:0] LAST_VEC = NVARS'(TW - 1);

   state_t           r_state, w_next;
   logic [NVARS-1:0] r_vec;
   logic             r_busy, r_done, r_mismatch;
   logic [TW-1:0]    r_sop, r_pos;
   logic [NVARS:0]   r_cnt;
   logic             w_diff, w_last, w_stop, w_expired, w_settle_load, w_settle_en;

   assign w_diff = bus.fs_in ^ bus.fp_in;
   assign w_last = (r_vec == LAST_VEC);
`ifdef SWEEP_ERR_STOP_EN
   assign w_stop = w_last | w_diff;
`else
   assign w_stop = w_last;
`endif

   assign w_settle_load = (w_next == SETTLE) && (r_state != SETTLE);
   assign w_settle_en   = (r_state == SETTLE);

   func_sweep_settle #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_settle_load),
      .i_en      (w_settle_en),
      .o_expired (w_expired)
   );

   // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = LOAD;
         LOAD:    w_next = SETTLE;
         SETTLE:  if (w_expired) w_next = SAMPLE;
         SAMPLE:  w_next = w_stop ? DONE : SETTLE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_vec      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mismatch <= 1'b0;
         r_sop      <= '0;
         r_pos      <= '0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= (w_next == DONE);
         // Outputs are registered, so LOAD's effects are applied on the edge that enters LOAD.
         if ((r_state == IDLE) && bus.start) begin
            r_vec      <= '0;
            r_sop      <= '0;
            r_pos      <= '0;
            r_mismatch <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
         end
         if (r_state == SAMPLE) begin
            r_sop[r_vec] <= bus.fs_in;
            r_pos[r_vec] <= bus.fp_in;
            if (w_diff) begin
               r_mismatch <= 1'b1;
               r_cnt      <= r_cnt + (NVARS+1)'(1);
            end
            if (w_stop) r_busy <= 1'b0;
            else        r_vec  <= r_vec + NVARS'(1);
         end
      end
   end

   assign bus.vec_out      = r_vec;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.truth_sop    = r_sop;
   assign bus.truth_pos    = r_pos;
   assign bus.mismatch     = r_mismatch;
   assign bus.mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Self-checking bench for func_sweep_ctrl: directed steps plus random truth tables vs a table-level model.
module tb_func_sweep_ctrl;
   import func_sweep_pkg::*;

   localparam int N  = 3;
   localparam int S  = 1;
   localparam int TW = 8;

   typedef struct {
      logic [TW-1:0] sop;
      logic [TW-1:0] pos;
      logic          mis;
      logic [N:0]    cnt;
      int            n_vec;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [TW-1:0] sop_tbl, pos_tbl, dp_sop, dp_pos;
   int            n_checks = 0;
   int            n_pass = 0;

   func_sweep_ctrl_if #(.NVARS(N)) sw_if ();

   assign sw_if.fs_in = sop_tbl[sw_if.vec_out];
   assign sw_if.fp_in = pos_tbl[sw_if.vec_out];

   func_sweep_ctrl #(.NVARS(N), .SETTLE_CYC(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sw_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Datapath under test: FS = x'z + y, FP = (x+y+z)(x'+y).
   function automatic logic sop_f(input logic [2:0] v);
      return (~v[2] & v[0]) | v[1];
   endfunction

   function automatic logic pos_f(input logic [2:0] v);
      return (v[2] | v[1] | v[0]) & (~v[2] | v[1]);
   endfunction

   // Expected sweep result straight from the truth tables.
   function automatic exp_t model(input logic [TW-1:0] s, input logic [TW-1:0] p);
      exp_t e;
      e.sop = '0; e.pos = '0; e.mis = 1'b0; e.cnt = '0; e.n_vec = TW;
      for (int i = 0; i < TW; i++) begin
         e.sop[i] = s[i];
         e.pos[i] = p[i];
         if (s[i] != p[i]) begin
            e.mis = 1'b1;
            e.cnt = e.cnt + 1;
`ifdef SWEEP_ERR_STOP_EN
            e.n_vec = i + 1;
            break;
`endif
         end
      end
      return e;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, ".vec"},  32'(sw_if.vec_out), 0);
      check({tag, ".busy"}, 32'(sw_if.busy), 0);
      check({tag, ".done"}, 32'(sw_if.done), 0);
      check({tag, ".tsop"}, 32'(sw_if.truth_sop), 0);
      check({tag, ".tpos"}, 32'(sw_if.truth_pos), 0);
      check({tag, ".mis"},  32'(sw_if.mismatch), 0);
      check({tag, ".cnt"},  32'(sw_if.mismatch_cnt), 0);
   endtask

   task automatic check_result(input string tag, input exp_t e);
      check({tag, ".tsop"}, 32'(sw_if.truth_sop), 32'(e.sop));
      check({tag, ".tpos"}, 32'(sw_if.truth_pos), 32'(e.pos));
      check({tag, ".mis"},  32'(sw_if.mismatch), 32'(e.mis));
      check({tag, ".cnt"},  32'(sw_if.mismatch_cnt), 32'(e.cnt));
   endtask

   // One sweep from a start pulse (or a start held high) with edge-by-edge timing checks.
   task automatic run_sweep(input string tag, input bit hold);
      exp_t e;
      int   done_edge, exp_vec, busy_err, vec_err, done_err, n;
      bit   found;
      e = model(sop_tbl, pos_tbl);
      done_edge = 2 + e.n_vec * (S + 1);
      busy_err = 0; vec_err = 0; done_err = 0;
      @(negedge clk);
      sw_if.start = 1'b1;
      for (int ed = 1; ed <= done_edge; ed++) begin
         @(posedge clk);
         #1;
         if (!hold) sw_if.start = 1'b0;
         exp_vec = (ed < 2) ? 0 : (ed - 2) / (S + 1);
         if (exp_vec > e.n_vec - 1) exp_vec = e.n_vec - 1;
         if (sw_if.busy !== (ed < done_edge)) busy_err++;
         if (sw_if.done !== (ed == done_edge)) done_err++;
         if (32'(sw_if.vec_out) != exp_vec) vec_err++;
      end
      check({tag, ".busy_seq"}, busy_err, 0);
      check({tag, ".done_seq"}, done_err, 0);
      check({tag, ".vec_seq"},  vec_err, 0);
      check_result(tag, e);
      @(posedge clk);
      #1;
      check({tag, ".done_pulse"}, 32'(sw_if.done), 0);
      check({tag, ".idle_busy"},  32'(sw_if.busy), 0);
      check({tag, ".idle_vec"},   32'(sw_if.vec_out), 32'(e.n_vec - 1));
      if (hold) begin
         @(posedge clk);
         #1;
         check({tag, ".retrigger"}, 32'(sw_if.busy), 1);
         sw_if.start = 1'b0;
         n = 0; found = 1'b0;
         while (!found && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (sw_if.done === 1'b1) found = 1'b1;
         end
         check({tag, ".retrig_done_edge"}, n, done_edge - 1);
         check_result({tag, ".retrig"}, e);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int n;
      sw_if.start = 1'b0;
      sop_tbl = '0;
      pos_tbl = '0;
      for (int i = 0; i < TW; i++) begin
         dp_sop[i] = sop_f(3'(i));
         dp_pos[i] = pos_f(3'(i));
      end

      // 1. reset, then idle without start
      #12;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("idle.vec", 32'(sw_if.vec_out), 0);
      end
      check_zero("idle");

      // 2. real SOP/POS datapath
      sop_tbl = dp_sop;
      pos_tbl = dp_pos;
      run_sweep("dp", 1'b0);
      check("dp.sop_ce", 32'(sw_if.truth_sop), 32'h0CE);
      check("dp.pos_ce", 32'(sw_if.truth_pos), 32'h0CE);
      check("dp.cnt0",   32'(sw_if.mismatch_cnt), 0);

      // 3. / 6. POS output stuck at 0
      pos_tbl = '0;
      run_sweep("fp0", 1'b0);
`ifdef SWEEP_ERR_STOP_EN
      check("fp0.stop_vec", 32'(sw_if.vec_out), 1);
      check("fp0.stop_cnt", 32'(sw_if.mismatch_cnt), 1);
      check("fp0.stop_sop", 32'(sw_if.truth_sop), 32'h02);
`else
      check("fp0.pos00", 32'(sw_if.truth_pos), 0);
      check("fp0.sop_ce", 32'(sw_if.truth_sop), 32'h0CE);
      check("fp0.cnt5",  32'(sw_if.mismatch_cnt), 5);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("fp0.hold_sop", 32'(sw_if.truth_sop), 32'(model(sop_tbl, pos_tbl).sop));

      // 4. start held high across a whole sweep
      sop_tbl = dp_sop;
      pos_tbl = dp_pos ^ 8'h21;
      run_sweep("hold", 1'b1);

      // random truth tables
      for (int k = 0; k < 4; k++) begin
         sop_tbl = 8'($urandom);
         pos_tbl = (k == 0) ? sop_tbl : sop_tbl ^ 8'($urandom);
         run_sweep("rand", 1'b0);
      end

      // 5. reset mid-sweep at vec_out == 4
      sop_tbl = 8'($urandom);
      pos_tbl = sop_tbl;
      @(negedge clk);
      sw_if.start = 1'b1;
      @(posedge clk);
      #1;
      sw_if.start = 1'b0;
      n = 0;
      while (sw_if.vec_out !== 3'd4 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("abort.reach4", 32'(sw_if.vec_out), 4);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort.no_restart", 32'(sw_if.busy), 0);
      run_sweep("after_abort", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
